// File: rtl/p405s_mmu_pkg.sv
// rtl/p405s_mmu_pkg.sv - shared MMU constants, reload FSM encoding and attribute bundle
package p405s_mmu_pkg;

    localparam int EPN_W   = 22;
    localparam int DSIZE_W = 7;
    localparam int NUM_ENT = 4;
    localparam int PTR_W   = $clog2(NUM_ENT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_EXC,
        S_DRAIN
    } reload_state_t;

    typedef struct packed {
        logic e;
        logic i;
        logic u0;
    } tlb_attr_t;

endpackage

// File: rtl/p405s_itlb_reload_ctl_if.sv
// rtl/p405s_itlb_reload_ctl_if.sv - UTLB lookup request/response port of the ITLB reload sequencer
interface p405s_itlb_reload_ctl_if;
    import p405s_mmu_pkg::*;

    logic               utlbReq;
    logic [EPN_W-1:0]   utlbEA;
    logic               utlbGnt;
    logic               utlbRspVld;
    logic               utlbHit;
    logic [EPN_W-1:0]   utlbRPN;
    logic [DSIZE_W-1:0] utlbDSize;
    logic               utlbE;
    logic               utlbI;
    logic               utlbU0;

    modport master (
        output utlbReq, utlbEA,
        input  utlbGnt, utlbRspVld, utlbHit, utlbRPN, utlbDSize, utlbE, utlbI, utlbU0
    );

    modport slave (
        input  utlbReq, utlbEA,
        output utlbGnt, utlbRspVld, utlbHit, utlbRPN, utlbDSize, utlbE, utlbI, utlbU0
    );

endinterface

// File: rtl/p405s_itlb_victim_ptr.sv
// rtl/p405s_itlb_victim_ptr.sv - round-robin shadow TLB victim pointer with sync clear
module p405s_itlb_victim_ptr
    import p405s_mmu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PTR_W'(NUM_ENT - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/p405s_itlb_reload_ctl.sv
// rtl/p405s_itlb_reload_ctl.sv - ITLB miss reload / shadow invalidate sequencer
module p405s_itlb_reload_ctl
    import p405s_mmu_pkg::*;
(
    input  logic                 CB,
    input  logic                 resetCore,
    input  logic                 fetchValid,
    input  logic                 msrIR,
    input  logic                 itlbMiss,
    input  logic [EPN_W-1:0]     fetchEPN,
    input  logic                 fetchAbort,
    input  logic                 invReq,
    p405s_itlb_reload_ctl_if.master utlb,
    output logic [PTR_W-1:0]     isAddr,
    output logic                 isrdNotWrt,
    output logic                 isAbort,
    output logic                 isInvalidate,
    output logic [EPN_W-1:0]     RPN,
    output logic [DSIZE_W-1:0]   DSize,
    output logic                 E,
    output logic                 I,
    output logic                 U0,
    output logic                 invAck,
    output logic                 fetchStall,
    output logic                 itlbMissExc
);

    reload_state_t      state, state_nxt;
    logic [EPN_W-1:0]   ea_q;
    logic [EPN_W-1:0]   rpn_q;
    logic [DSIZE_W-1:0] dsize_q;
    tlb_attr_t          attr_q;
    logic               inv_pend_q;
    logic [PTR_W-1:0]   victim;

    logic miss_start, inv_go;
    logic req, stall, wr, exc, inval, ea_ld, cap;

    assign miss_start = fetchValid & msrIR & itlbMiss & ~fetchAbort;
    assign inv_go     = (state == S_IDLE) & (invReq | inv_pend_q);

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        stall     = 1'b0;
        wr        = 1'b0;
        exc       = 1'b0;
        inval     = 1'b0;
        ea_ld     = 1'b0;
        cap       = 1'b0;
        case (state)
            S_IDLE: begin
                if (inv_go) begin
                    inval = 1'b1;
                end else if (miss_start) begin
                    ea_ld     = 1'b1;
                    stall     = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                req   = 1'b1;
                stall = 1'b1;
                // A grant coincident with the abort still owes us a response, so drain it
                if (fetchAbort)   state_nxt = utlb.utlbGnt ? S_DRAIN : S_IDLE;
                else if (utlb.utlbGnt) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (fetchAbort) begin
                    state_nxt = utlb.utlbRspVld ? S_IDLE : S_DRAIN;
                end else if (utlb.utlbRspVld) begin
                    cap       = utlb.utlbHit;
                    state_nxt = utlb.utlbHit ? S_WRITE : S_EXC;
                end
            end
            S_WRITE: begin
                wr        = 1'b1;
                stall     = 1'b1;
                state_nxt = S_IDLE;
            end
            S_EXC: begin
                exc       = 1'b1;
                state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (utlb.utlbRspVld) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CB or posedge resetCore) begin
        if (resetCore) begin
            state      <= S_IDLE;
            ea_q       <= '0;
            rpn_q      <= '0;
            dsize_q    <= '0;
            attr_q     <= '0;
            inv_pend_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ea_ld) ea_q <= fetchEPN;
            if (cap) begin
                rpn_q   <= utlb.utlbRPN;
                dsize_q <= utlb.utlbDSize;
                attr_q  <= '{e: utlb.utlbE, i: utlb.utlbI, u0: utlb.utlbU0};
            end
            if (inv_go)                           inv_pend_q <= 1'b0;
            else if (state != S_IDLE && invReq)   inv_pend_q <= 1'b1;
        end
    end

    p405s_itlb_victim_ptr u_victim (
        .clk (CB),
        .rst (resetCore),
        .clr (inval),
        .inc (wr),
        .ptr (victim)
    );

    // Combinational outputs are forced to their reset values while reset is held
    assign utlb.utlbReq = req & ~resetCore;
    assign utlb.utlbEA  = ea_q;
    assign fetchStall   = stall & ~resetCore;
    assign isrdNotWrt   = ~wr | resetCore;
    assign isAbort      = ~wr & ~resetCore;
    assign isAddr       = wr ? victim : '0;
    assign isInvalidate = inval & ~resetCore;
    assign invAck       = inval & ~resetCore;
    assign itlbMissExc  = exc & ~resetCore;
    assign RPN          = rpn_q;
    assign DSize        = dsize_q;
    assign E            = attr_q.e;
    assign I            = attr_q.i;
    assign U0           = attr_q.u0;

endmodule

// File: tb/tb_p405s_itlb_reload_ctl.sv
// tb/tb_p405s_itlb_reload_ctl.sv - directed self-checking bench for the ITLB reload sequencer
module tb_p405s_itlb_reload_ctl;
    import p405s_mmu_pkg::*;

    logic               CB = 1'b0;
    logic               resetCore, fetchValid, msrIR, itlbMiss, fetchAbort, invReq;
    logic [EPN_W-1:0]   fetchEPN;
    logic [PTR_W-1:0]   isAddr;
    logic               isrdNotWrt, isAbort, isInvalidate, E, I, U0, invAck, fetchStall, itlbMissExc;
    logic [EPN_W-1:0]   RPN;
    logic [DSIZE_W-1:0] DSize;

    int n_cmp = 0;
    int n_bad = 0;

    p405s_itlb_reload_ctl_if u_if ();

    p405s_itlb_reload_ctl dut (
        .CB           (CB),
        .resetCore    (resetCore),
        .fetchValid   (fetchValid),
        .msrIR        (msrIR),
        .itlbMiss     (itlbMiss),
        .fetchEPN     (fetchEPN),
        .fetchAbort   (fetchAbort),
        .invReq       (invReq),
        .utlb         (u_if),
        .isAddr       (isAddr),
        .isrdNotWrt   (isrdNotWrt),
        .isAbort      (isAbort),
        .isInvalidate (isInvalidate),
        .RPN          (RPN),
        .DSize        (DSize),
        .E            (E),
        .I            (I),
        .U0           (U0),
        .invAck       (invAck),
        .fetchStall   (fetchStall),
        .itlbMissExc  (itlbMissExc)
    );

    always #5 CB = ~CB;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CB);
        #1;
    endtask

    task automatic do_reload(input logic [EPN_W-1:0] epn, input logic [EPN_W-1:0] rpn,
                             input logic [DSIZE_W-1:0] dsz, input logic [2:0] attr,
                             input logic [PTR_W-1:0] exp_addr);
        fetchValid = 1'b1; msrIR = 1'b1; itlbMiss = 1'b1; fetchEPN = epn;
        #1 chk("c0_stall", 32'(fetchStall), 32'd1);
        chk("c0_noreq", 32'(u_if.utlbReq), 32'd0);
        tick();
        itlbMiss = 1'b0; u_if.utlbGnt = 1'b1;
        #1 chk("c1_req", 32'(u_if.utlbReq), 32'd1);
        chk("c1_ea", 32'(u_if.utlbEA), 32'(epn));
        tick();
        u_if.utlbGnt = 1'b0; u_if.utlbRspVld = 1'b1; u_if.utlbHit = 1'b1;
        u_if.utlbRPN = rpn; u_if.utlbDSize = dsz;
        {u_if.utlbE, u_if.utlbI, u_if.utlbU0} = attr;
        #1 chk("c2_nowrite", 32'(isrdNotWrt), 32'd1);
        chk("c2_stall", 32'(fetchStall), 32'd1);
        tick();
        u_if.utlbRspVld = 1'b0; u_if.utlbHit = 1'b0;
        #1 chk("c3_write", 32'(isrdNotWrt), 32'd0);
        chk("c3_addr", 32'(isAddr), 32'(exp_addr));
        chk("c3_abort", 32'(isAbort), 32'd0);
        chk("c3_rpn", 32'(RPN), 32'(rpn));
        chk("c3_dsize", 32'(DSize), 32'(dsz));
        chk("c3_attr", 32'({E, I, U0}), 32'(attr));
        chk("c3_stall", 32'(fetchStall), 32'd1);
        tick();
        #1 chk("c4_rd", 32'(isrdNotWrt), 32'd1);
        chk("c4_stall", 32'(fetchStall), 32'd0);
    endtask

    initial begin
        resetCore = 1'b1; fetchValid = 1'b1; msrIR = 1'b1; itlbMiss = 1'b1;
        fetchAbort = 1'b0; invReq = 1'b0; fetchEPN = 22'h12345;
        u_if.utlbGnt = 1'b0; u_if.utlbRspVld = 1'b0; u_if.utlbHit = 1'b0;
        u_if.utlbRPN = '0; u_if.utlbDSize = '0;
        u_if.utlbE = 1'b0; u_if.utlbI = 1'b0; u_if.utlbU0 = 1'b0;

        // Reset values
        #1 chk("rst_rd", 32'(isrdNotWrt), 32'd1);
        chk("rst_abort", 32'(isAbort), 32'd0);
        chk("rst_stall", 32'(fetchStall), 32'd0);
        chk("rst_req", 32'(u_if.utlbReq), 32'd0);
        chk("rst_ea", 32'(u_if.utlbEA), 32'd0);
        chk("rst_rpn", 32'(RPN), 32'd0);
        chk("rst_misc", 32'({isAddr, isInvalidate, invAck, itlbMissExc, E, I, U0, DSize}), 32'd0);
        tick(); tick();
        resetCore = 1'b0; itlbMiss = 1'b0; fetchValid = 1'b0;
        #1 chk("idle_abort", 32'(isAbort), 32'd1);

        // First reload plus four more: round-robin 0,1,2,3,0
        do_reload(22'h12345, 22'h0ABCD, 7'h05, 3'b101, 2'd0);
        do_reload(22'h00100, 22'h00200, 7'h01, 3'b010, 2'd1);
        do_reload(22'h00101, 22'h00201, 7'h7F, 3'b111, 2'd2);
        do_reload(22'h3FFFFF, 22'h3FFFFE, 7'h40, 3'b000, 2'd3);
        do_reload(22'h00102, 22'h00202, 7'h02, 3'b001, 2'd0);

        // UTLB miss -> exception, pointer stays at 1
        fetchValid = 1'b1; itlbMiss = 1'b1; fetchEPN = 22'h00555;
        tick();
        itlbMiss = 1'b0; u_if.utlbGnt = 1'b1;
        tick();
        u_if.utlbGnt = 1'b0; u_if.utlbRspVld = 1'b1; u_if.utlbHit = 1'b0;
        tick();
        u_if.utlbRspVld = 1'b0;
        #1 chk("exc_pulse", 32'(itlbMissExc), 32'd1);
        chk("exc_nowrite", 32'(isrdNotWrt), 32'd1);
        chk("exc_stall", 32'(fetchStall), 32'd0);
        tick();
        #1 chk("exc_once", 32'(itlbMissExc), 32'd0);
        do_reload(22'h00556, 22'h00666, 7'h03, 3'b100, 2'd1);

        // Abort in WAIT -> DRAIN, response 3 cycles later discarded, miss in DRAIN ignored
        fetchValid = 1'b1; itlbMiss = 1'b1; fetchEPN = 22'h00777;
        tick();
        itlbMiss = 1'b0; u_if.utlbGnt = 1'b1;
        tick();
        u_if.utlbGnt = 1'b0; fetchAbort = 1'b1;
        #1 chk("wait_stall", 32'(fetchStall), 32'd1);
        tick();
        fetchAbort = 1'b0; itlbMiss = 1'b1; fetchEPN = 22'h00888;
        #1 chk("drain_stall", 32'(fetchStall), 32'd0);
        chk("drain_req", 32'(u_if.utlbReq), 32'd0);
        tick();
        #1 chk("drain_noreq", 32'(u_if.utlbReq), 32'd0);
        tick();
        itlbMiss = 1'b0; u_if.utlbRspVld = 1'b1; u_if.utlbHit = 1'b1; u_if.utlbRPN = 22'h3ABCDE;
        #1 chk("drain_rsp_rd", 32'(isrdNotWrt), 32'd1);
        tick();
        u_if.utlbRspVld = 1'b0; u_if.utlbHit = 1'b0;
        #1 chk("drain_nowrite", 32'(isrdNotWrt), 32'd1);
        chk("drain_noexc", 32'(itlbMissExc), 32'd0);
        chk("drain_idle_req", 32'(u_if.utlbReq), 32'd0);
        chk("drain_ea", 32'(u_if.utlbEA), 32'h00777);

        // invReq during WAIT: write completes at 2, invalidate next cycle, pointer -> 0
        fetchValid = 1'b1; itlbMiss = 1'b1; fetchEPN = 22'h2AAAA;
        tick();
        itlbMiss = 1'b0; u_if.utlbGnt = 1'b1;
        tick();
        u_if.utlbGnt = 1'b0; u_if.utlbRspVld = 1'b1; u_if.utlbHit = 1'b1;
        u_if.utlbRPN = 22'h15555; invReq = 1'b1;
        tick();
        u_if.utlbRspVld = 1'b0; u_if.utlbHit = 1'b0;
        #1 chk("inv_write", 32'(isrdNotWrt), 32'd0);
        chk("inv_waddr", 32'(isAddr), 32'd2);
        chk("inv_wrpn", 32'(RPN), 32'h15555);
        chk("inv_not_yet", 32'({isInvalidate, invAck}), 32'd0);
        tick();
        #1 chk("inv_pulse", 32'({isInvalidate, invAck}), 32'b11);
        tick();
        invReq = 1'b0;
        #1 chk("inv_done", 32'({isInvalidate, invAck}), 32'd0);
        do_reload(22'h00900, 22'h00901, 7'h04, 3'b011, 2'd0);

        // invReq in IDLE beats a coincident miss and clears the pointer (1 -> 0)
        invReq = 1'b1; fetchValid = 1'b1; itlbMiss = 1'b1; fetchEPN = 22'h00A00;
        #1 chk("idle_inv", 32'(isInvalidate), 32'd1);
        chk("idle_inv_nostall", 32'(fetchStall), 32'd0);
        tick();
        invReq = 1'b0; itlbMiss = 1'b0;
        #1 chk("idle_inv_noreq", 32'(u_if.utlbReq), 32'd0);
        do_reload(22'h00A01, 22'h00A02, 7'h06, 3'b110, 2'd0);

        // Abort in REQ: request drops next cycle, back to IDLE
        fetchValid = 1'b1; itlbMiss = 1'b1; fetchEPN = 22'h00B00;
        tick();
        itlbMiss = 1'b0; fetchAbort = 1'b1;
        #1 chk("reqab_req", 32'(u_if.utlbReq), 32'd1);
        tick();
        fetchAbort = 1'b0;
        #1 chk("reqab_drop", 32'(u_if.utlbReq), 32'd0);
        chk("reqab_stall", 32'(fetchStall), 32'd0);

        // Real mode: misses ignored
        msrIR = 1'b0; itlbMiss = 1'b1;
        #1 chk("real_stall", 32'(fetchStall), 32'd0);
        tick();
        #1 chk("real_noreq", 32'(u_if.utlbReq), 32'd0);
        itlbMiss = 1'b0; msrIR = 1'b1;

        // Reset while WAIT has a hit response in hand: no write, outputs to reset values
        fetchValid = 1'b1; itlbMiss = 1'b1; fetchEPN = 22'h1F00F;
        tick();
        itlbMiss = 1'b0; u_if.utlbGnt = 1'b1;
        tick();
        u_if.utlbGnt = 1'b0; u_if.utlbRspVld = 1'b1; u_if.utlbHit = 1'b1;
        u_if.utlbRPN = 22'h2F0F0; resetCore = 1'b1;
        #1 chk("mrst_rd", 32'(isrdNotWrt), 32'd1);
        chk("mrst_abort", 32'(isAbort), 32'd0);
        chk("mrst_stall", 32'(fetchStall), 32'd0);
        chk("mrst_ea", 32'(u_if.utlbEA), 32'd0);
        chk("mrst_rpn", 32'(RPN), 32'd0);
        tick();
        u_if.utlbRspVld = 1'b0; u_if.utlbHit = 1'b0;
        #1 chk("mrst_nowrite", 32'(isrdNotWrt), 32'd1);
        chk("mrst_noexc", 32'(itlbMissExc), 32'd0);
        resetCore = 1'b0;
        #1 chk("mrst_idle_req", 32'(u_if.utlbReq), 32'd0);
        do_reload(22'h1F00F, 22'h0F0F0, 7'h08, 3'b101, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/p405s_itlb_reload_ctl.md
Name: p405s_itlb_reload_ctl

Overview:
Reload sequencer for the 4-entry instruction shadow TLB (ITLB). On an ITLB miss during translated fetch, it requests a lookup from the unified TLB (UTLB), then writes the returned translation into a round-robin victim entry, or raises an instruction-TLB-miss exception if the UTLB also misses. It also sequences shadow invalidates (context sync, tlbia/tlbwe). It drives the ITLB's write and address controls and stalls fetch while a reload is in flight.

Parameters:
EPN_W, 22, effective/real page number width (bits 0:21)
NUM_ENT, 4, shadow entries; victim pointer is log2(NUM_ENT) bits
DSIZE_W, 7, page-size decode width

Ports:
CB  in  1  core clock; all state updates on rising edge
resetCore  in  1  reset, asynchronous, active-high
fetchValid  in  1  fetch address valid this cycle
msrIR  in  1  instruction relocation enabled
itlbMiss  in  1  miss from ITLB compare, same cycle as fetchEPN
fetchEPN  in  EPN_W  EPN of current fetch
fetchAbort  in  1  fetch flushed (branch/interrupt)
invReq  in  1  request shadow invalidate (level, held until invAck)
utlbReq  out  1  UTLB lookup request
utlbEA  out  EPN_W  latched miss EPN
utlbGnt  in  1  UTLB accepts request
utlbRspVld  in  1  UTLB response valid, one cycle
utlbHit  in  1  response hit
utlbRPN  in  EPN_W  response real page number
utlbDSize  in  DSIZE_W  response page size
utlbE, utlbI, utlbU0  in  1 each  response attributes
isAddr  out  2  ITLB entry select (victim pointer when writing)
isrdNotWrt  out  1  0 = write shadow entry this cycle
isAbort  out  1  suppress shadow write
isInvalidate  out  1  invalidate all shadow entries, one cycle
RPN, DSize, E, I, U0  out  EPN_W/DSIZE_W/1/1/1  write data to ITLB
invAck  out  1  invalidate done, one cycle
fetchStall  out  1  hold fetch
itlbMissExc  out  1  instruction TLB miss exception, one cycle

Behaviour:
- Reset values: all outputs 0 except isrdNotWrt=1; state IDLE; victim pointer 0; write-data regs 0; pending-invalidate 0.
- States: IDLE, REQ, WAIT, WRITE, EXC, DRAIN.
- IDLE: missStart = fetchValid & msrIR & itlbMiss & ~fetchAbort. If invReq (priority over missStart): isInvalidate=1 and invAck=1 that cycle, victim pointer <= 0, stay IDLE. Else if missStart: latch fetchEPN into utlbEA, fetchStall=1 combinationally, -> REQ.
- REQ: utlbReq=1, fetchStall=1; utlbGnt -> WAIT. fetchAbort in REQ -> IDLE, utlbReq dropped next cycle, no UTLB transaction.
- WAIT: fetchStall=1; on utlbRspVld: utlbHit -> capture RPN/DSize/E/I/U0, -> WRITE; ~utlbHit -> EXC. fetchAbort without utlbRspVld -> DRAIN; fetchAbort coincident with utlbRspVld -> IDLE, response discarded.
- DRAIN: fetchStall=0; wait for utlbRspVld, discard, -> IDLE. A new missStart is not accepted in DRAIN.
- WRITE: isrdNotWrt=0, isAddr=victim pointer, isAbort=0, write data stable for 1 cycle; victim pointer <= (ptr+1) mod NUM_ENT (3 wraps to 0); fetchStall=1; -> IDLE. Fetch replays next cycle and hits.
- EXC: itlbMissExc=1 for one cycle, fetchStall=0, no write, pointer unchanged; -> IDLE.
- Outside WRITE: isrdNotWrt=1, isAbort=1, isAddr = fetchEPN-independent 0 (reads address-independent CAM match).
- invReq arriving while not IDLE: recorded in pending flag; serviced on first IDLE cycle before any new miss. Invalidate never interrupts WRITE.
- msrIR=0: misses ignored (real mode supplied by ITLB real attributes).
- Latency: miss detected in cycle 0 -> utlbReq cycle 1; with gnt in cycle 1 and rsp in cycle 2, write in cycle 3, fetch replay cycle 4.
- resetCore mid-reload: immediate return to IDLE, no write, no exception.

Decomposition:
- Shared package p405s_mmu_pkg: state encoding enum, EPN_W/DSIZE_W/NUM_ENT constants, attribute bundle typedef {E,I,U0}.
- One sub-module: p405s_itlb_victim_ptr (round-robin counter with sync clear and increment enable).

Test Plan:
- Miss at EPN 0x12345, gnt same cycle, rsp hit RPN 0x0ABCD two cycles later -> isrdNotWrt=0 with isAddr=0, RPN=0x0ABCD in cycle 3; pointer becomes 1.
- Five consecutive hit reloads -> write addresses 0,1,2,3,0.
- UTLB miss response -> itlbMissExc pulse one cycle, no write, pointer unchanged, fetchStall drops.
- fetchAbort in WAIT, rsp arrives 3 cycles later -> DRAIN, no write/exception; a missStart during DRAIN is ignored.
- invReq during WAIT -> reload completes write, next cycle isInvalidate=1 and invAck=1, pointer=0.
- resetCore asserted in WRITE-bound WAIT -> all outputs to reset values asynchronously, no write pulse.
